// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio types and widths for the recorder and playback stages
package audio_pkg;

    localparam int AUDIO_SAMPLE_W = 8;
    localparam int AUDIO_ADDR_W   = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECORD = 2'd1,
        DONE   = 2'd2
    } rec_state_t;

endpackage

// File: rtl/recorder.sv
// rtl/recorder.sv - captures strobed audio samples into the sample-memory write port
module recorder
    import audio_pkg::*;
#(
    parameter int ADDR_W   = AUDIO_ADDR_W,
    parameter int SAMPLE_W = AUDIO_SAMPLE_W
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic                start_record,
    input  logic                stop_record,
    input  logic                signal_12khz,
    input  logic [SAMPLE_W-1:0] audio_in,
    output logic                wr_en_out,
    output logic [ADDR_W-1:0]   wr_addr_out,
    output logic [SAMPLE_W-1:0] wr_data_out,
    output logic [ADDR_W:0]     length_out,
    output logic                recording_out,
    output logic                done_out,
    output logic                full_out
);

    localparam logic [ADDR_W:0] LAST_ADDR = {1'b0, {ADDR_W{1'b1}}};

    rec_state_t      state;
    rec_state_t      state_next;
    logic            sig_q;
    logic            strobe_edge;
    logic [ADDR_W:0] count;
    logic [ADDR_W:0] count_next;
    logic            accept;
    logic            finish;
    logic            hit_full;
    logic            clear;

    assign strobe_edge = signal_12khz & ~sig_q;
    assign count_next  = count + {{ADDR_W{1'b0}}, accept};

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        finish     = 1'b0;
        hit_full   = 1'b0;
        clear      = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start_record) begin
                    state_next = RECORD;
                    clear      = 1'b1;
                end
            end
            RECORD: begin
                accept   = strobe_edge;
                hit_full = strobe_edge && (count == LAST_ADDR);
                // Filling memory ends the capture in the same cycle as the last write.
                if (stop_record || hit_full) begin
                    state_next = DONE;
                    finish     = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state         <= IDLE;
            sig_q         <= 1'b0;
            count         <= '0;
            length_out    <= '0;
            wr_en_out     <= 1'b0;
            wr_addr_out   <= '0;
            wr_data_out   <= '0;
            done_out      <= 1'b0;
            full_out      <= 1'b0;
            recording_out <= 1'b0;
        end else begin
            state         <= state_next;
            sig_q         <= signal_12khz;
            wr_en_out     <= accept;
            done_out      <= finish;
            recording_out <= (state_next == RECORD);
            if (accept) begin
                wr_addr_out <= count[ADDR_W-1:0];
                wr_data_out <= audio_in;
            end
            if (clear) begin
                count    <= '0;
                full_out <= 1'b0;
            end else begin
                count <= count_next;
                if (hit_full)
                    full_out <= 1'b1;
            end
            // Length only moves at the end of a capture so playback never sees a partial value.
            if (finish)
                length_out <= count_next;
        end
    end

endmodule

// File: doc/recorder.md
RECORDER -- requirements
Module: recorder

Interface
REQ-001: Parameter ADDR_W, default 16, sample-memory address width (depth 2**ADDR_W = 65536 samples, ~5.46 s at 12 kHz).
REQ-002: Parameter SAMPLE_W, default 8, audio sample width, unsigned offset-binary.
REQ-003: clk_in  input  1  system clock, 100 MHz; the only clock.
REQ-004: rst_n_in  input  1  synchronous active-low reset; also driven on new game.
REQ-005: start_record  input  1  one-cycle request to begin a new capture.
REQ-006: stop_record  input  1  one-cycle request to end the current capture.
REQ-007: signal_12khz  input  1  sample-rate strobe; only its rising edge is used.
REQ-008: audio_in  input  SAMPLE_W  microphone/ADC sample, stable around the strobe.
REQ-009: wr_en_out  output  1  sample-memory write enable.
REQ-010: wr_addr_out  output  ADDR_W  sample-memory write address.
REQ-011: wr_data_out  output  SAMPLE_W  sample-memory write data.
REQ-012: length_out  output  ADDR_W+1  number of valid samples captured; read by the playback stage.
REQ-013: recording_out  output  1  high while in state RECORD.
REQ-014: done_out  output  1  one-cycle pulse when a capture ends.
REQ-015: full_out  output  1  high when the last capture ended by filling memory.

Function
REQ-016: States: IDLE, RECORD, DONE.
REQ-017: Strobe edge = signal_12khz high this cycle and low the previous cycle (one registered history bit); a strobe held high for N cycles counts once.
REQ-018: IDLE or DONE + start_record -> RECORD next cycle; write count and full_out cleared to 0 on entry.
REQ-019: RECORD + strobe edge -> next cycle: wr_en_out=1, wr_addr_out=count, wr_data_out=audio_in as registered on the edge cycle; count increments by 1; latency exactly 1 cycle.
REQ-020: wr_en_out SHALL be high for exactly one cycle per accepted strobe edge and never outside RECORD-originated writes.
REQ-021: RECORD + stop_record -> DONE next cycle; done_out pulses that cycle; length_out = count.
REQ-022: stop_record and strobe edge in the same cycle -> that sample is written, then DONE; length_out includes it.
REQ-023: Write to address 2**ADDR_W-1 -> DONE in the same cycle as that write, full_out=1, done_out pulses, length_out=2**ADDR_W; no address wrap.
REQ-024: start_record in RECORD is ignored; stop_record in IDLE or DONE is ignored.
REQ-025: start_record and stop_record together in IDLE/DONE -> start wins; in RECORD -> stop wins.
REQ-026: Stop before any strobe edge -> length_out=0, done_out pulses, no writes.
REQ-027: length_out holds its value in DONE and through a new start until that capture ends; it changes only when done_out pulses, so playback never sees a partial length.
REQ-028: recording_out is a registered decode of state RECORD.

Reset
REQ-029: rst_n_in low at a clock edge -> state IDLE, count=0, length_out=0, wr_en_out=0, wr_addr_out=0, wr_data_out=0, done_out=0, full_out=0, recording_out=0, strobe history=0.
REQ-030: Reset mid-RECORD aborts without done_out and without a final write; reset has priority over every other input.

Structure
REQ-031: Shared package audio_pkg holds the state enum (IDLE/RECORD/DONE), SAMPLE_W and default ADDR_W, also used by playback.
REQ-032: No sub-module; sample BRAM is instantiated by the parent, with recorder on write port and playback on read port.

Verification (ADDR_W=4 unless noted)
REQ-033: Reset, start, 3 strobe edges with audio_in 0x10,0x20,0x30, stop -> writes addr 0,1,2 data 0x10,0x20,0x30; done_out one pulse; length_out=3.
REQ-034: Start, 16 strobe edges -> 16th write at addr 15 and done_out in the same cycle, full_out=1, length_out=16; 17th strobe produces no write.
REQ-035: signal_12khz held high 5 cycles during RECORD -> exactly one write.
REQ-036: Stop coincident with 2nd strobe edge -> 2 writes, length_out=2; start then immediate stop -> 0 writes, length_out=0, done_out pulses.
REQ-037: rst_n_in low after 5 writes -> all outputs 0 next cycle, no done_out; new capture starts at addr 0.
REQ-038: ADDR_W=16, 12 kHz strobe for 1 ms after start -> 12 writes spaced 83.33 us, length_out=12 after stop.
